// File: rtl/sn_dispatch_if.sv
// Snooper/core bundle for sn_dispatch. The slave modport is the dispatcher and
// the master modport is the snooper plus the p3 cores around it.
interface sn_dispatch_if #(
  parameter int NUM_CORES         = 4,
  parameter int SEL_WIDTH         = 2,
  parameter int SN_FWD_ADDR_WIDTH = 9,
  parameter int DATA_WIDTH        = 64,
  parameter int INC_WIDTH         = 8
) ();
  logic [SN_FWD_ADDR_WIDTH-1:0] sn_addr;
  logic [DATA_WIDTH-1:0]        sn_wr_data;
  logic                         sn_wr_en;
  logic [INC_WIDTH-1:0]         sn_byte_inc;
  logic                         sn_done;
  logic                         sn_done_ack;
  logic                         rdy_for_sn;
  logic                         rdy_for_sn_ack;
  logic [SN_FWD_ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0]        core_wr_data;
  logic [INC_WIDTH-1:0]         core_byte_inc;
  logic [NUM_CORES-1:0]         core_wr_en;
  logic [NUM_CORES-1:0]         core_done;
  logic [NUM_CORES-1:0]         core_done_ack;
  logic [NUM_CORES-1:0]         core_rdy;
  logic [NUM_CORES-1:0]         core_rdy_ack;
  logic [SEL_WIDTH-1:0]         cur_sel;
  logic [31:0]                  pkt_cnt;
  logic [15:0]                  drop_cnt;

  modport master (
    output sn_addr, sn_wr_data, sn_wr_en, sn_byte_inc, sn_done, rdy_for_sn_ack,
           core_done_ack, core_rdy,
    input  sn_done_ack, rdy_for_sn, core_addr, core_wr_data, core_byte_inc,
           core_wr_en, core_done, core_rdy_ack, cur_sel, pkt_cnt, drop_cnt
  );

  modport slave (
    input  sn_addr, sn_wr_data, sn_wr_en, sn_byte_inc, sn_done, rdy_for_sn_ack,
           core_done_ack, core_rdy,
    output sn_done_ack, rdy_for_sn, core_addr, core_wr_data, core_byte_inc,
           core_wr_en, core_done, core_rdy_ack, cur_sel, pkt_cnt, drop_cnt
  );
endinterface

// File: rtl/sn_dispatch.sv
// Round-robin dispatcher sharing one snooper write stream among NUM_CORES p3 cores.
// Define SN_DISPATCH_BUF_EN to add one register stage on the write/done paths.
module sn_dispatch #(
  parameter int NUM_CORES         = 4,
  parameter int SEL_WIDTH         = 2,
  parameter int SN_FWD_ADDR_WIDTH = 9,
  parameter int DATA_WIDTH        = 64,
  parameter int INC_WIDTH         = 8
) (
  input  logic         clk,
  input  logic         rst,
  sn_dispatch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } state_e;

  state_e               state_q;
  logic [SEL_WIDTH-1:0] cur_sel_q;
  logic [SEL_WIDTH-1:0] last_grant_q;
  logic                 rdy_for_sn_q;
  logic [31:0]          pkt_cnt_q;
  logic [15:0]          drop_cnt_q;

  logic [SEL_WIDTH-1:0] pick_sel_d;
  logic                 pick_vld_d;
  logic [SEL_WIDTH-1:0] cand;
  logic [NUM_CORES-1:0] sel_oh;
  logic                 busy;
  logic                 claim;
  logic                 done_hs;
  logic                 drop;

  // Scan starts just after the last granted core so every ready core gets a turn.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_sel_d = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      cand = SEL_WIDTH'((int'(last_grant_q) + i) % NUM_CORES);
      if (!pick_vld_d && bus.core_rdy[cand]) begin
        pick_vld_d = 1'b1;
        pick_sel_d = cand;
      end
    end
  end

  always_comb begin
    sel_oh            = '0;
    sel_oh[cur_sel_q] = 1'b1;
  end

  assign busy  = (state_q == BUSY);
  assign claim = (state_q == OFFER) && bus.rdy_for_sn_ack;
  assign drop  = bus.sn_wr_en && !busy;

  assign bus.core_rdy_ack = claim ? sel_oh : '0;
  assign bus.sn_done_ack  = done_hs;
  assign bus.rdy_for_sn   = rdy_for_sn_q;
  assign bus.cur_sel      = cur_sel_q;
  assign bus.pkt_cnt      = pkt_cnt_q;
  assign bus.drop_cnt     = drop_cnt_q;

`ifdef SN_DISPATCH_BUF_EN
  logic [NUM_CORES-1:0]         wr_oh_q;
  logic [NUM_CORES-1:0]         done_oh_q;
  logic [SN_FWD_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]        data_q;
  logic [INC_WIDTH-1:0]         inc_q;

  // Done is dropped from the stage once its handshake completes, so the core
  // never sees a stale done after the dispatcher has returned to IDLE.
  assign done_hs = busy && |(done_oh_q & bus.core_done_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_oh_q   <= '0;
      done_oh_q <= '0;
    end else begin
      wr_oh_q   <= (busy && bus.sn_wr_en) ? sel_oh : '0;
      done_oh_q <= (busy && bus.sn_done && !done_hs) ? sel_oh : '0;
    end
  end

  // NOTE: the broadcast datapath carries no reset; it is qualified by the strobes.
  always_ff @(posedge clk) begin
    addr_q <= bus.sn_addr;
    data_q <= bus.sn_wr_data;
    inc_q  <= bus.sn_byte_inc;
  end

  assign bus.core_wr_en    = wr_oh_q;
  assign bus.core_done     = done_oh_q;
  assign bus.core_addr     = addr_q;
  assign bus.core_wr_data  = data_q;
  assign bus.core_byte_inc = inc_q;
`else
  assign done_hs           = busy && bus.sn_done && bus.core_done_ack[cur_sel_q];
  assign bus.core_wr_en    = (busy && bus.sn_wr_en) ? sel_oh : '0;
  assign bus.core_done     = (busy && bus.sn_done) ? sel_oh : '0;
  assign bus.core_addr     = bus.sn_addr;
  assign bus.core_wr_data  = bus.sn_wr_data;
  assign bus.core_byte_inc = bus.sn_byte_inc;
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_sel_q    <= '0;
      last_grant_q <= SEL_WIDTH'(NUM_CORES - 1);
      rdy_for_sn_q <= 1'b0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            cur_sel_q    <= pick_sel_d;
            rdy_for_sn_q <= 1'b1;
            state_q      <= OFFER;
          end
        end
        OFFER: begin
          // A claim in the same cycle as the core withdrawing still wins.
          if (bus.rdy_for_sn_ack) begin
            last_grant_q <= cur_sel_q;
            rdy_for_sn_q <= 1'b0;
            state_q      <= BUSY;
          end else if (!bus.core_rdy[cur_sel_q]) begin
            rdy_for_sn_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        BUSY: begin
          if (done_hs) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
            state_q   <= IDLE;
          end
        end
        default: begin
          rdy_for_sn_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase

      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sn_dispatch.sv
// Self-checking bench for sn_dispatch: randomized packets against a round-robin
// model, with latency taken from SN_DISPATCH_BUF_EN.
module tb_sn_dispatch;
  localparam int NUM_CORES = 4;
  localparam int SEL_WIDTH = 2;
  localparam int AW        = 9;
  localparam int DW        = 64;
  localparam int IW        = 8;
`ifdef SN_DISPATCH_BUF_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  int          model_last;
  int unsigned model_pkt;
  int          model_drop;

  sn_dispatch_if #(
    .NUM_CORES(NUM_CORES), .SEL_WIDTH(SEL_WIDTH), .SN_FWD_ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .INC_WIDTH(IW)
  ) bus ();

  sn_dispatch #(
    .NUM_CORES(NUM_CORES), .SEL_WIDTH(SEL_WIDTH), .SN_FWD_ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .INC_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int model_pick(input logic [NUM_CORES-1:0] rdy);
    logic [NUM_CORES-1:0] sh;
    for (int i = 1; i <= NUM_CORES; i++) begin
      int idx;
      idx = (model_last + i) % NUM_CORES;
      sh  = rdy >> idx;
      if (sh[0]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NUM_CORES-1:0] onehot(input int s);
    return NUM_CORES'(1) << s;
  endfunction

  task automatic drive_idle();
    bus.sn_addr        = '0;
    bus.sn_wr_data     = '0;
    bus.sn_wr_en       = 1'b0;
    bus.sn_byte_inc    = '0;
    bus.sn_done        = 1'b0;
    bus.rdy_for_sn_ack = 1'b0;
    bus.core_done_ack  = '0;
    bus.core_rdy       = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    model_last = NUM_CORES - 1;
    model_pkt  = 0;
    model_drop = 0;
  endtask

  // Offer and claim of the model's chosen core; entered and left just after an edge.
  task automatic claim(input logic [NUM_CORES-1:0] rdy, output int sel, output int got_sel);
    sel = model_pick(rdy);
    bus.core_rdy = rdy;
    #1;
    checks++;
    if (bus.rdy_for_sn !== 1'b0) begin
      errors++; $display("FAIL idle_rdy_for_sn: got %0h want 0", bus.rdy_for_sn);
    end
    @(posedge clk); #1;
    got_sel = int'(bus.cur_sel);
    checks++;
    if (bus.cur_sel !== SEL_WIDTH'(sel)) begin
      errors++; $display("FAIL grant_sel: got %0d want %0d", bus.cur_sel, sel);
    end
    checks++;
    if (bus.rdy_for_sn !== 1'b1) begin
      errors++; $display("FAIL offer_rdy_for_sn: got %0h want 1", bus.rdy_for_sn);
    end
    bus.rdy_for_sn_ack = 1'b1;
    #1;
    checks++;
    if (bus.core_rdy_ack !== onehot(sel)) begin
      errors++; $display("FAIL claim_rdy_ack: got %b want %b", bus.core_rdy_ack, onehot(sel));
    end
    @(posedge clk); #1;
    bus.rdy_for_sn_ack = 1'b0;
    model_last = sel;
    #1;
    checks++;
    if (bus.rdy_for_sn !== 1'b0 || bus.core_rdy_ack !== '0) begin
      errors++; $display("FAIL busy_no_offer: got rdy=%0h ack=%b want rdy=0 ack=0",
                         bus.rdy_for_sn, bus.core_rdy_ack);
    end
  endtask

  // Holds done with foreign acks first, then the selected core acks it.
  task automatic finish_done(input int sel, input int exp_lat);
    logic [NUM_CORES-1:0] oh;
    int waited;
    oh = onehot(sel);
    waited = -1;
    bus.sn_done       = 1'b1;
    bus.core_done_ack = ~oh;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.core_done === oh) begin
        waited = c;
        break;
      end
      checks++;
      if (bus.sn_done_ack !== 1'b0) begin
        errors++; $display("FAIL done_ack_early: got %0h want 0", bus.sn_done_ack);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (waited != exp_lat) begin
      errors++; $display("FAIL done_latency: got %0d want %0d", waited, exp_lat);
    end
    if (waited >= 0) begin
      checks++;
      if (bus.sn_done_ack !== 1'b0) begin
        errors++; $display("FAIL foreign_done_ack: got %0h want 0", bus.sn_done_ack);
      end
      bus.core_done_ack = oh;
      #1;
      checks++;
      if (bus.sn_done_ack !== 1'b1) begin
        errors++; $display("FAIL sn_done_ack: got %0h want 1", bus.sn_done_ack);
      end
      @(posedge clk); #1;
      bus.sn_done       = 1'b0;
      bus.core_done_ack = '0;
      model_pkt++;
      #1;
      checks++;
      if (bus.pkt_cnt !== 32'(model_pkt)) begin
        errors++; $display("FAIL pkt_cnt: got %0d want %0d", bus.pkt_cnt, model_pkt);
      end
      checks++;
      if (bus.core_done !== '0 || bus.sn_done_ack !== 1'b0) begin
        errors++; $display("FAIL done_release: got done=%b ack=%0h want 0", bus.core_done, bus.sn_done_ack);
      end
    end
  endtask

  task automatic run_packet(input logic [NUM_CORES-1:0] rdy, input int nwr, input bit fixed,
                            output int got_sel);
    int sel;
    logic [NUM_CORES-1:0] oh;
    logic [AW-1:0] a [8];
    logic [DW-1:0] d [8];
    logic [IW-1:0] n [8];
    claim(rdy, sel, got_sel);
    oh = onehot(sel);
    for (int k = 0; k < nwr; k++) begin
      a[k] = fixed ? AW'(k) : AW'($urandom);
      d[k] = fixed ? 64'hA5A5_A5A5_A5A5_A5A5 : {$urandom, $urandom};
      n[k] = fixed ? 8'd8 : IW'($urandom);
    end
    for (int k = 0; k < nwr + LAT; k++) begin
      if (k < nwr) begin
        bus.sn_wr_en    = 1'b1;
        bus.sn_addr     = a[k];
        bus.sn_wr_data  = d[k];
        bus.sn_byte_inc = n[k];
      end else begin
        bus.sn_wr_en = 1'b0;
      end
      #1;
      if (k >= LAT) begin
        int j;
        j = k - LAT;
        checks++;
        if (bus.core_wr_en !== oh) begin
          errors++; $display("FAIL wr_en: got %b want %b", bus.core_wr_en, oh);
        end
        checks++;
        if (bus.core_addr !== a[j] || bus.core_wr_data !== d[j] || bus.core_byte_inc !== n[j]) begin
          errors++; $display("FAIL wr_bus: got %0h/%0h/%0h want %0h/%0h/%0h", bus.core_addr,
                             bus.core_wr_data, bus.core_byte_inc, a[j], d[j], n[j]);
        end
      end else begin
        checks++;
        if (bus.core_wr_en !== '0) begin
          errors++; $display("FAIL wr_en_early: got %b want 0", bus.core_wr_en);
        end
      end
      @(posedge clk); #1;
    end
    bus.sn_wr_en = 1'b0;
    finish_done(sel, LAT);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    #3;
    checks++;
    if (bus.rdy_for_sn !== 1'b0 || bus.cur_sel !== '0 || bus.pkt_cnt !== '0 || bus.drop_cnt !== '0) begin
      errors++; $display("FAIL reset_regs: got rdy=%0h sel=%0d pkt=%0d drop=%0d want all 0",
                         bus.rdy_for_sn, bus.cur_sel, bus.pkt_cnt, bus.drop_cnt);
    end
    checks++;
    if (bus.core_wr_en !== '0 || bus.core_done !== '0 || bus.core_rdy_ack !== '0 || bus.sn_done_ack !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: got wr=%b done=%b rack=%b dack=%0h want 0",
                         bus.core_wr_en, bus.core_done, bus.core_rdy_ack, bus.sn_done_ack);
    end
    do_reset();
    @(posedge clk); #1;
    checks++;
    if (bus.rdy_for_sn !== 1'b0) begin
      errors++; $display("FAIL idle_no_ready: got %0h want 0", bus.rdy_for_sn);
    end
  endtask

  task automatic test_basic();
    int got;
    do_reset();
    run_packet(4'b0110, 3, 1'b1, got);
    checks++;
    if (got != 1) begin
      errors++; $display("FAIL basic_grant: got %0d want 1", got);
    end
  endtask

  task automatic test_fairness();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    int got;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      run_packet(4'b1111, int'($urandom_range(1, 3)), 1'b0, got);
      checks++;
      if (got != exp_seq[p]) begin
        errors++; $display("FAIL fair_grant%0d: got %0d want %0d", p, got, exp_seq[p]);
      end
    end
  endtask

  task automatic test_random();
    int got;
    for (int p = 0; p < 10; p++) begin
      run_packet(NUM_CORES'($urandom_range(1, 15)), int'($urandom_range(0, 4)), 1'b0, got);
    end
  endtask

  task automatic test_drop();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      bus.sn_wr_en = 1'b1;
      bus.sn_addr  = AW'($urandom);
      #1;
      if (bus.core_wr_en !== '0) bad++;
      @(posedge clk); #1;
      model_drop++;
    end
    bus.sn_wr_en = 1'b0;
    #1;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL drop_forwarded: got %0d forwarded want 0", bad);
    end
    checks++;
    if (bus.drop_cnt !== 16'(model_drop)) begin
      errors++; $display("FAIL drop_cnt5: got %0d want %0d", bus.drop_cnt, model_drop);
    end
    bus.rdy_for_sn_ack = 1'b1;
    bus.sn_done        = 1'b1;
    bus.core_done_ack  = '1;
    #1;
    checks++;
    if (bus.core_rdy_ack !== '0 || bus.sn_done_ack !== 1'b0 || bus.core_done !== '0) begin
      errors++; $display("FAIL idle_ignore: got rack=%b dack=%0h done=%b want 0",
                         bus.core_rdy_ack, bus.sn_done_ack, bus.core_done);
    end
    @(posedge clk); #1;
    drive_idle();
    #1;
    checks++;
    if (bus.rdy_for_sn !== 1'b0 || bus.pkt_cnt !== 32'(model_pkt)) begin
      errors++; $display("FAIL idle_stays: got rdy=%0h pkt=%0d want 0/%0d", bus.rdy_for_sn, bus.pkt_cnt, model_pkt);
    end
    bus.sn_wr_en = 1'b1;
    for (int i = 0; i < 65534 - 5; i++) begin
      @(posedge clk);
      if (model_drop < 65535) model_drop++;
    end
    #1;
    bus.sn_wr_en = 1'b0;
    #1;
    checks++;
    if (bus.drop_cnt !== 16'(model_drop) || model_drop != 65534) begin
      errors++; $display("FAIL drop_cnt_fffe: got %0h want %0h", bus.drop_cnt, 16'(model_drop));
    end
    bus.sn_wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      if (model_drop < 65535) model_drop++;
    end
    #1;
    bus.sn_wr_en = 1'b0;
    #1;
    checks++;
    if (bus.drop_cnt !== 16'(model_drop)) begin
      errors++; $display("FAIL drop_cnt_sat: got %0h want %0h", bus.drop_cnt, 16'(model_drop));
    end
  endtask

  task automatic test_offer_drop();
    do_reset();
    bus.core_rdy = 4'b0100;
    @(posedge clk); #1;
    checks++;
    if (bus.cur_sel !== SEL_WIDTH'(model_pick(4'b0100)) || bus.rdy_for_sn !== 1'b1) begin
      errors++; $display("FAIL offer2: got sel=%0d rdy=%0h want 2/1", bus.cur_sel, bus.rdy_for_sn);
    end
    bus.core_rdy = '0;
    #1;
    checks++;
    if (bus.core_rdy_ack !== '0) begin
      errors++; $display("FAIL withdraw_ack: got %b want 0", bus.core_rdy_ack);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rdy_for_sn !== 1'b0 || bus.core_rdy_ack !== '0) begin
      errors++; $display("FAIL withdraw_fall: got rdy=%0h ack=%b want 0", bus.rdy_for_sn, bus.core_rdy_ack);
    end
    // Re-offer, then claim and withdraw together: the claim must win.
    bus.core_rdy = 4'b0100;
    @(posedge clk); #1;
    bus.core_rdy       = '0;
    bus.rdy_for_sn_ack = 1'b1;
    #1;
    checks++;
    if (bus.core_rdy_ack !== 4'b0100) begin
      errors++; $display("FAIL ack_wins: got %b want 0100", bus.core_rdy_ack);
    end
    @(posedge clk); #1;
    bus.rdy_for_sn_ack = 1'b0;
    model_last         = 2;
    bus.sn_wr_en       = 1'b1;
    bus.sn_addr        = AW'($urandom);
    if (LAT != 0) begin
      @(posedge clk); #1;
      bus.sn_wr_en = 1'b0;
    end
    #1;
    checks++;
    if (bus.core_wr_en !== 4'b0100) begin
      errors++; $display("FAIL ack_wins_busy: got %b want 0100", bus.core_wr_en);
    end
    bus.sn_wr_en = 1'b1;
    bus.sn_done  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.core_wr_en !== '0 || bus.core_done !== '0 || bus.rdy_for_sn !== 1'b0 ||
        bus.cur_sel !== '0 || bus.pkt_cnt !== '0 || bus.drop_cnt !== '0 || bus.sn_done_ack !== 1'b0) begin
      errors++; $display("FAIL mid_busy_reset: got wr=%b done=%b rdy=%0h sel=%0d pkt=%0d drop=%0d want 0",
                         bus.core_wr_en, bus.core_done, bus.rdy_for_sn, bus.cur_sel, bus.pkt_cnt, bus.drop_cnt);
    end
    drive_idle();
    @(posedge clk); #1;
    rst        = 1'b0;
    model_last = NUM_CORES - 1;
    model_pkt  = 0;
    model_drop = 0;
    bus.core_rdy = 4'b1111;
    @(posedge clk); #1;
    checks++;
    if (bus.cur_sel !== SEL_WIDTH'(model_pick(4'b1111)) || bus.rdy_for_sn !== 1'b1) begin
      errors++; $display("FAIL post_reset_grant: got sel=%0d rdy=%0h want 0/1", bus.cur_sel, bus.rdy_for_sn);
    end
    bus.core_rdy = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_wr_done_same_cycle();
    int sel;
    int got;
    logic [NUM_CORES-1:0] oh;
    do_reset();
    claim(NUM_CORES'($urandom_range(1, 15)), sel, got);
    oh = onehot(sel);
    bus.sn_wr_en = 1'b1;
    bus.sn_addr  = AW'($urandom);
    bus.sn_done  = 1'b1;
    #1;
    if (LAT != 0) begin
      checks++;
      if (bus.core_wr_en !== '0 || bus.core_done !== '0) begin
        errors++; $display("FAIL same_cycle_early: got wr=%b done=%b want 0", bus.core_wr_en, bus.core_done);
      end
      @(posedge clk); #1;
      bus.sn_wr_en = 1'b0;
      #1;
    end
    checks++;
    if (bus.core_wr_en !== oh || bus.core_done !== oh) begin
      errors++; $display("FAIL same_cycle: got wr=%b done=%b want %b", bus.core_wr_en, bus.core_done, oh);
    end
    bus.sn_wr_en = 1'b0;
    finish_done(sel, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_last = NUM_CORES - 1;
    model_pkt  = 0;
    model_drop = 0;
    test_reset();
    test_basic();
    test_fairness();
    test_random();
    test_drop();
    test_offer_drop();
    test_wr_done_same_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sn_dispatch.md
Name: sn_dispatch

Overview:
- Snooper-side scheduler that shares one snooper write stream among NUM_CORES packet-filter cores.
- Each core has its own p3 buffer system.
- Selects a ready core round-robin, offers it to the snooper, routes the packet's writes to that core, then relays the done handshake.
- Sits between the snooper and the snooper ports of every p3 instance.

Parameters:
NUM_CORES, 4, number of downstream p3 instances (2..16)
SEL_WIDTH, 2, width of core index; equals clog2(NUM_CORES)
SN_FWD_ADDR_WIDTH, 9, snooper word-address width
DATA_WIDTH, 64, snooper write-data width
INC_WIDTH, 8, byte-increment width

Ports:
clk  in  1  single clock for the block
rst  in  1  asynchronous, active-high reset
sn_addr  in  SN_FWD_ADDR_WIDTH  snooper write address
sn_wr_data  in  DATA_WIDTH  snooper write data
sn_wr_en  in  1  snooper write strobe
sn_byte_inc  in  INC_WIDTH  bytes added by this write
sn_done  in  1  packet complete; held until sn_done_ack
sn_done_ack  out  1  single-cycle ack of sn_done
rdy_for_sn  out  1  a core is offered to the snooper
rdy_for_sn_ack  in  1  single-cycle claim of the offered core
core_addr  out  SN_FWD_ADDR_WIDTH  broadcast address to all cores
core_wr_data  out  DATA_WIDTH  broadcast write data
core_byte_inc  out  INC_WIDTH  broadcast byte increment
core_wr_en  out  NUM_CORES  one-hot write strobe, bit sel only
core_done  out  NUM_CORES  one-hot done to selected core
core_done_ack  in  NUM_CORES  per-core done ack
core_rdy  in  NUM_CORES  per-core rdy_for_sn
core_rdy_ack  out  NUM_CORES  one-hot claim pulse to selected core
cur_sel  out  SEL_WIDTH  registered index of the selected core
pkt_cnt  out  32  packets completed; wraps at 2^32
drop_cnt  out  16  writes dropped outside BUSY; saturates at 16'hFFFF

Behaviour:
- Reset (async, any state): state=IDLE, last_grant=NUM_CORES-1, cur_sel=0, pkt_cnt=0, drop_cnt=0. All outputs 0 except broadcast data, which is don't-care.
- IDLE: if core_rdy != 0, pick the first set bit scanning last_grant+1, +2, … modulo NUM_CORES. Register it into cur_sel and go to OFFER next cycle (1-cycle latency). Otherwise stay in IDLE.
- OFFER: rdy_for_sn=1.
  - If core_rdy[cur_sel] drops before the claim, go to IDLE with rdy_for_sn=0 next cycle.
  - On rdy_for_sn_ack, core_rdy_ack[cur_sel]=1 combinationally in the same cycle. Set last_grant=cur_sel and go to BUSY.
  - If rdy_for_sn_ack and a core_rdy drop happen together, the ack wins.
- BUSY:
  - core_wr_en[cur_sel]=sn_wr_en. Address, data and byte increment are broadcast.
  - core_done[cur_sel]=sn_done.
  - When core_done_ack[cur_sel]=1 while done is forwarded: sn_done_ack=1 that cycle, pkt_cnt+1, next state IDLE.
- Writes: sn_wr_en while not BUSY is not forwarded; drop_cnt increments, saturating. rdy_for_sn_ack outside OFFER is ignored. sn_done outside BUSY is ignored and never acked.
- sn_wr_en and sn_done in the same BUSY cycle: both are forwarded in that cycle.
- core_done_ack from a non-selected core is ignored.
- No second grant is issued before the current packet's done handshake completes. At most one bit is set in any one-hot output.

Optional Feature:
- Macro SN_DISPATCH_BUF_EN.
- Defined: address, data, byte increment, per-core wr_en and per-core done pass through one register stage (+1 cycle), all delayed equally so the final write lands no later than done. sn_done_ack and the exit from BUSY occur on core_done_ack of the registered done. Dropped-write counting uses the undelayed strobe.
- Undefined: write and done paths are combinational (0-cycle).

Test Plan:
- Reset, core_rdy=4'b0110 -> cur_sel=1 after 1 cycle, rdy_for_sn=1; ack -> core_rdy_ack=4'b0010; BUSY.
- In BUSY on core 1: 3 writes addr 0,1,2, data 64'hA5.., inc 8 -> core_wr_en=4'b0010 each cycle; sn_done; core_done_ack[1] -> sn_done_ack pulse, pkt_cnt=1.
- Fairness: core_rdy=4'b1111 held, 4 packets -> grants 0,1,2,3; a fifth packet grants 0.
- In IDLE, 5 writes with no core ready -> core_wr_en=0, drop_cnt=5; with drop_cnt preloaded to 16'hFFFE and 3 writes -> 16'hFFFF.
- core_rdy[2] drops during OFFER -> rdy_for_sn falls, no core_rdy_ack; rst asserted mid-BUSY -> all outputs 0 immediately, next grant core 0.
- With SN_DISPATCH_BUF_EN: a write and done in the same cycle -> core_wr_en and core_done both appear 1 cycle later, on the same cycle.
